// File: rtl/qr_givens_scheduler.sv
// Sequencing controller for a Givens-rotation QR decomposition on one shared rotation unit.
// Optional macro QR_SKIP_ZERO_EN: skip rotations whose target element is already zero.
module qr_givens_scheduler #(
   parameter int N       = 4,
   parameter int IDX_W   = 3,
   parameter int TIMEOUT = 1024
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic             i_abort,
   output logic             o_load,
   output logic             o_cmd_valid,
   input  logic             i_cmd_ready,
   output logic [IDX_W-1:0] o_cmd_col,
   output logic [IDX_W-1:0] o_cmd_row_p,
   output logic [IDX_W-1:0] o_cmd_row_t,
   output logic             o_cmd_last,
   input  logic             i_rot_done,
   input  logic             i_tgt_zero,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err,
   output logic [5:0]       o_rot_count
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_ISSUE  = 3'd2;
   localparam logic [2:0] S_WAIT   = 3'd3;
   localparam logic [2:0] S_FINISH = 3'd4;

   localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [IDX_W-1:0] LP_K_LAST  = IDX_W'(N - 2);
   localparam logic [IDX_W-1:0] LP_J_LAST  = IDX_W'(N - 1);
   localparam logic [WD_W-1:0]  LP_WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

   logic [2:0]       r_state;
   logic [IDX_W-1:0] r_k;
   logic [IDX_W-1:0] r_j;
   logic [5:0]       r_count;
   logic [WD_W-1:0]  r_wd;
   logic             r_load;
   logic             r_cmd_valid;
   logic             r_cmd_last;
   logic             r_busy;
   logic             r_done;
   logic             r_err;

   logic [2:0]       w_state_d;
   logic [IDX_W-1:0] w_k_d;
   logic [IDX_W-1:0] w_j_d;
   logic [5:0]       w_count_d;
   logic [WD_W-1:0]  w_wd_d;
   logic             w_timeout;
   logic             w_is_last;
   logic [IDX_W-1:0] w_adv_k;
   logic [IDX_W-1:0] w_adv_j;
   logic             w_skip;

`ifdef QR_SKIP_ZERO_EN
   assign w_skip = (r_state == S_ISSUE) && i_tgt_zero;
`else
   // tgt_zero has no effect in this build
   assign w_skip = i_tgt_zero & 1'b0;
`endif

   assign o_load      = r_load;
   assign o_cmd_valid = r_cmd_valid & ~w_skip;
   assign o_cmd_col   = r_k;
   assign o_cmd_row_p = r_k;
   assign o_cmd_row_t = r_j;
   assign o_cmd_last  = r_cmd_last;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_err       = r_err;
   assign o_rot_count = r_count;

   // Column-major successor of (k, j)
   always_comb begin
      w_is_last = (r_k == LP_K_LAST) && (r_j == LP_J_LAST);
      if (r_j == LP_J_LAST) begin
         w_adv_k = r_k + 1'b1;
         w_adv_j = r_k + IDX_W'(2);
      end else begin
         w_adv_k = r_k;
         w_adv_j = r_j + 1'b1;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_k_d     = r_k;
      w_j_d     = r_j;
      w_count_d = r_count;
      w_timeout = 1'b0;
      w_wd_d    = (r_state == S_WAIT) ? r_wd + 1'b1 : '0;

      case (r_state)
         S_IDLE: begin
            if (i_start && !i_abort) begin
               w_state_d = S_LOAD;
               w_k_d     = '0;
               w_j_d     = IDX_W'(1);
               w_count_d = '0;
            end
         end
         S_LOAD: w_state_d = S_ISSUE;
         S_ISSUE: begin
            if (w_skip) begin
               w_count_d = r_count + 1'b1;
               if (w_is_last) begin
                  w_state_d = S_FINISH;
               end else begin
                  w_k_d = w_adv_k;
                  w_j_d = w_adv_j;
               end
            end else if (o_cmd_valid && i_cmd_ready) begin
               w_state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // A completion on the timeout cycle takes precedence over the watchdog
            if (i_rot_done) begin
               w_count_d = r_count + 1'b1;
               if (w_is_last) begin
                  w_state_d = S_FINISH;
               end else begin
                  w_state_d = S_ISSUE;
                  w_k_d     = w_adv_k;
                  w_j_d     = w_adv_j;
               end
            end else if ((TIMEOUT != 0) && (r_wd == LP_WD_LAST)) begin
               w_timeout = 1'b1;
               w_state_d = S_IDLE;
            end
         end
         S_FINISH: w_state_d = S_IDLE;
         default:  w_state_d = S_IDLE;
      endcase

      if (i_abort && (r_state != S_IDLE)) begin
         w_state_d = S_IDLE;
         w_k_d     = r_k;
         w_j_d     = r_j;
         w_count_d = r_count;
         w_timeout = 1'b0;
      end
   end

   // Outputs are registered from the next state so they line up with the state they describe
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state     <= S_IDLE;
         r_k         <= '0;
         r_j         <= IDX_W'(1);
         r_count     <= '0;
         r_wd        <= '0;
         r_load      <= 1'b0;
         r_cmd_valid <= 1'b0;
         r_cmd_last  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_k         <= w_k_d;
         r_j         <= w_j_d;
         r_count     <= w_count_d;
         r_wd        <= w_wd_d;
         r_load      <= (w_state_d == S_LOAD);
         r_cmd_valid <= (w_state_d == S_ISSUE);
         r_cmd_last  <= (w_state_d == S_ISSUE) && (w_k_d == LP_K_LAST) && (w_j_d == LP_J_LAST);
         r_busy      <= (w_state_d != S_IDLE);
         r_done      <= (w_state_d == S_FINISH);
         r_err       <= w_timeout;
      end
   end

endmodule

// File: tb/tb_qr_givens_scheduler.sv
// Directed bench for qr_givens_scheduler: per-cycle timeline model built from the command list.
module tb_qr_givens_scheduler;
   localparam int N       = 4;
   localparam int IDX_W   = 3;
   localparam int TIMEOUT = 8;
   localparam int NCMD    = N * (N - 1) / 2;
   localparam int MAXC    = 64;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             start, abort, cmd_ready, rot_done, tgt_zero;
   logic             load, cmd_valid, cmd_last, busy, done, err;
   logic [IDX_W-1:0] cmd_col, cmd_row_p, cmd_row_t;
   logic [5:0]       rot_count;

   always #5 clk = ~clk;

   qr_givens_scheduler #(.N(N), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
      .i_clk(clk), .i_reset(reset_n), .i_start(start), .i_abort(abort),
      .o_load(load), .o_cmd_valid(cmd_valid), .i_cmd_ready(cmd_ready),
      .o_cmd_col(cmd_col), .o_cmd_row_p(cmd_row_p), .o_cmd_row_t(cmd_row_t),
      .o_cmd_last(cmd_last), .i_rot_done(rot_done), .i_tgt_zero(tgt_zero),
      .o_busy(busy), .o_done(done), .o_err(err), .o_rot_count(rot_count)
   );

   int total = 0;
   int bad = 0;
   int last_count = 0;
   int cmd_k [NCMD];
   int cmd_j [NCMD];

   logic in_start [MAXC], in_abort [MAXC], in_ready [MAXC], in_rdone [MAXC], in_tgt [MAXC];
   logic exp_load [MAXC], exp_valid [MAXC], exp_busy [MAXC], exp_done [MAXC], exp_err [MAXC];
   logic exp_last [MAXC];
   int   exp_k [MAXC], exp_j [MAXC], exp_count [MAXC];
   int   exp_len, exp_done_cyc;

   task automatic cmp(input string tag, input string what, input int c, input int act,
                      input int expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s %s cycle %0d: got %0d expected %0d", tag, what, c, act, expv);
      end
   endtask

   task automatic fill_count(input int from, input int val);
      for (int c = from; c < MAXC; c++) exp_count[c] = val;
   endtask

   // Builds stimulus and expected timeline; cycle 0 is the cycle start is presented
   task automatic build(input int stall_idx, input int stall_len, input int wd_idx,
                        input int wd_delay, input int abort_idx, input bit spur,
                        input int skip_mask, input bit start_abort);
      int t, cnt, sl, d;
      bit skip_en;
      skip_en = 1'b0;
`ifdef QR_SKIP_ZERO_EN
      skip_en = 1'b1;
`endif
      for (int c = 0; c < MAXC; c++) begin
         in_start[c] = 0; in_abort[c] = 0; in_ready[c] = 0; in_rdone[c] = 0; in_tgt[c] = 0;
         exp_load[c] = 0; exp_valid[c] = 0; exp_busy[c] = 0; exp_done[c] = 0; exp_err[c] = 0;
         exp_last[c] = 0; exp_k[c] = 0; exp_j[c] = 0;
      end
      fill_count(0, last_count);
      exp_done_cyc = -1;
      in_start[0] = 1;
      if (start_abort) begin
         in_abort[0] = 1;
         exp_len = 4;
         return;
      end
      exp_load[1] = 1; exp_busy[1] = 1;
      fill_count(1, 0);
      cnt = 0;
      t = 2;
      for (int i = 0; i < NCMD; i++) begin
         if (skip_mask[i]) in_tgt[t] = 1;
         if (skip_en && skip_mask[i]) begin
            exp_busy[t] = 1;
            cnt++;
            fill_count(t + 1, cnt);
            t++;
            continue;
         end
         sl = (i == stall_idx) ? stall_len : 0;
         for (int s = 0; s <= sl; s++) begin
            exp_valid[t+s] = 1; exp_busy[t+s] = 1;
            exp_k[t+s] = cmd_k[i]; exp_j[t+s] = cmd_j[i]; exp_last[t+s] = (i == NCMD - 1);
            in_ready[t+s] = (s == sl);
         end
         if (spur && i == 1) begin
            in_rdone[t] = 1;
            in_start[t] = 1;
         end
         t += sl + 1;
         if (i == abort_idx) begin
            in_abort[t] = 1; exp_busy[t] = 1;
            exp_len = t + 4;
            return;
         end
         d = (i == wd_idx) ? wd_delay : 0;
         if (d >= TIMEOUT) begin
            for (int x = 0; x < TIMEOUT; x++) exp_busy[t+x] = 1;
            exp_err[t+TIMEOUT] = 1;
            exp_len = t + TIMEOUT + 3;
            return;
         end
         for (int x = 0; x <= d; x++) exp_busy[t+x] = 1;
         in_rdone[t+d] = 1;
         t += d + 1;
         cnt++;
         fill_count(t, cnt);
      end
      exp_done[t] = 1; exp_busy[t] = 1;
      exp_done_cyc = t;
      exp_len = t + 3;
   endtask

   task automatic run(input string tag, input int done_lit, input int hs_lit);
      int hs, done_seen;
      hs = 0;
      done_seen = -1;
      cmp(tag, "model done cycle", 0, exp_done_cyc, done_lit);
      for (int c = 0; c < exp_len; c++) begin
         start = in_start[c]; abort = in_abort[c]; cmd_ready = in_ready[c];
         rot_done = in_rdone[c]; tgt_zero = in_tgt[c];
         #1;
         cmp(tag, "load", c, load, exp_load[c]);
         cmp(tag, "cmd_valid", c, cmd_valid, exp_valid[c]);
         cmp(tag, "busy", c, busy, exp_busy[c]);
         cmp(tag, "done", c, done, exp_done[c]);
         cmp(tag, "err", c, err, exp_err[c]);
         cmp(tag, "rot_count", c, rot_count, exp_count[c]);
         if (exp_valid[c]) begin
            cmp(tag, "cmd_col", c, cmd_col, exp_k[c]);
            cmp(tag, "cmd_row_p", c, cmd_row_p, exp_k[c]);
            cmp(tag, "cmd_row_t", c, cmd_row_t, exp_j[c]);
            cmp(tag, "cmd_last", c, cmd_last, exp_last[c]);
         end
         if (cmd_valid && cmd_ready) hs++;
         if (done && done_seen < 0) done_seen = c;
         @(posedge clk);
         #1;
      end
      start = 0; abort = 0; cmd_ready = 0; rot_done = 0; tgt_zero = 0;
      cmp(tag, "dut done cycle", 0, done_seen, done_lit);
      cmp(tag, "handshakes", 0, hs, hs_lit);
      last_count = exp_count[exp_len-1];
   endtask

   initial begin
      int idx;
      int lit_k [NCMD];
      int lit_j [NCMD];
      lit_k = '{0, 0, 0, 1, 1, 2};
      lit_j = '{1, 2, 3, 2, 3, 3};
      idx = 0;
      for (int k = 0; k < N - 1; k++)
         for (int j = k + 1; j < N; j++) begin
            cmd_k[idx] = k; cmd_j[idx] = j; idx++;
         end
      for (int i = 0; i < NCMD; i++) begin
         cmp("order", "k", i, cmd_k[i], lit_k[i]);
         cmp("order", "j", i, cmd_j[i], lit_j[i]);
      end

      start = 0; abort = 0; cmd_ready = 0; rot_done = 0; tgt_zero = 0;
      reset_n = 0;
      repeat (3) @(posedge clk);
      #1;
      cmp("reset", "load", 0, load, 0);
      cmp("reset", "cmd_valid", 0, cmd_valid, 0);
      cmp("reset", "cmd_last", 0, cmd_last, 0);
      cmp("reset", "busy", 0, busy, 0);
      cmp("reset", "done", 0, done, 0);
      cmp("reset", "err", 0, err, 0);
      cmp("reset", "cmd_col", 0, cmd_col, 0);
      cmp("reset", "cmd_row_p", 0, cmd_row_p, 0);
      cmp("reset", "cmd_row_t", 0, cmd_row_t, 1);
      cmp("reset", "rot_count", 0, rot_count, 0);
      reset_n = 1;
      @(posedge clk);
      #1;

      build(-1, 0, -1, 0, -1, 0, 0, 0);             run("nominal", 14, 6);
      build(3, 5, -1, 0, -1, 0, 0, 0);              run("backpressure", 19, 6);
      build(-1, 0, -1, 0, -1, 1, 0, 0);             run("protocol", 14, 6);
      build(-1, 0, -1, 0, 2, 0, 0, 0);              run("abort", -1, 3);
      build(-1, 0, -1, 0, -1, 0, 0, 1);             run("start_abort", -1, 0);
      build(-1, 0, 0, TIMEOUT, -1, 0, 0, 0);        run("watchdog", -1, 1);
      build(-1, 0, 0, TIMEOUT - 1, -1, 0, 0, 0);    run("watchdog_race", 21, 6);
      build(-1, 0, -1, 0, -1, 0, 'b100010, 0);
`ifdef QR_SKIP_ZERO_EN
      run("skip", 12, 4);
`else
      run("skip", 14, 6);
`endif

      // Asynchronous reset in the middle of a run
      start = 1;
      @(posedge clk);
      #1;
      start = 0;
      repeat (4) @(posedge clk);
      #2;
      reset_n = 0;
      #1;
      cmp("midreset", "busy", 0, busy, 0);
      cmp("midreset", "cmd_valid", 0, cmd_valid, 0);
      cmp("midreset", "rot_count", 0, rot_count, 0);
      cmp("midreset", "cmd_row_t", 0, cmd_row_t, 1);
      @(posedge clk);
      #1;
      reset_n = 1;
      @(posedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
